// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access engine: funct3 width codes, FSM states, bus geometry.
package mem_pkg;

  localparam int XLEN   = 64;
  localparam int NBYTES = XLEN / 8;

  localparam logic [2:0] MW_B  = 3'b000;
  localparam logic [2:0] MW_H  = 3'b001;
  localparam logic [2:0] MW_W  = 3'b010;
  localparam logic [2:0] MW_D  = 3'b011;
  localparam logic [2:0] MW_BU = 3'b100;
  localparam logic [2:0] MW_HU = 3'b101;
  localparam logic [2:0] MW_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: misalignment check, store mask/data placement, load extract and extend.
module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]  width,
  input  logic [63:0] addr,
  input  logic [63:0] rs2,
  output logic        misaligned,
  output logic [7:0]  wmask,
  output logic [63:0] wdata,
  input  logic [2:0]  ld_width,
  input  logic [2:0]  ld_off,
  input  logic [63:0] rdata,
  output logic [63:0] ld_ext
);

  logic [2:0]  off;
  logic [63:0] x;

  assign off = addr[2:0];

  always_comb begin
    misaligned = 1'b0;
    wmask      = 8'h00;
    case (width)
      MW_B, MW_BU: begin
        misaligned = 1'b0;
        wmask      = 8'h01 << off;
      end
      MW_H, MW_HU: begin
        misaligned = addr[0];
        wmask      = 8'h03 << off;
      end
      MW_W, MW_WU: begin
        misaligned = |addr[1:0];
        wmask      = 8'h0F << off;
      end
      default: begin
        // Width 111 is not a legal funct3 here; it behaves as a doubleword.
        misaligned = |addr[2:0];
        wmask      = 8'hFF;
      end
    endcase
  end

  assign wdata = rs2 << {off, 3'b000};
  assign x     = rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_ext = x;
    case (ld_width)
      MW_B:    ld_ext = {{56{x[7]}}, x[7:0]};
      MW_H:    ld_ext = {{48{x[15]}}, x[15:0]};
      MW_W:    ld_ext = {{32{x[31]}}, x[31:0]};
      MW_BU:   ld_ext = {56'd0, x[7:0]};
      MW_HU:   ld_ext = {48'd0, x[15:0]};
      MW_WU:   ld_ext = {32'd0, x[31:0]};
      default: ld_ext = x;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory engine: one aligned 64-bit bus transaction per load/store, stalling the pipe until done.
module mem_access_unit #(
  parameter int XLEN   = mem_pkg::XLEN,
  parameter int NBYTES = mem_pkg::NBYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_mem,
  input  logic              kill_mem,
  input  logic              flush,
  input  logic              pipe_stall,
  input  logic              is_load_mem,
  input  logic              we_mem_mem,
  input  logic [2:0]        memdata_width_mem,
  input  logic [XLEN-1:0]   alu_res_mem,
  input  logic [XLEN-1:0]   rs2_data_mem,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [XLEN-1:0]   req_addr,
  output logic [XLEN-1:0]   req_wdata,
  output logic [NBYTES-1:0] req_wmask,
  input  logic              resp_valid,
  input  logic [XLEN-1:0]   resp_rdata,
  output logic              mem_stall,
  output logic [XLEN-1:0]   load_data,
  output logic              misalign_exc,
  output logic              misalign_store,
  output logic [XLEN-1:0]   bad_addr,
  output logic [1:0]        fsm_state
);

  import mem_pkg::*;

  // Bus handshake: a request is transferred on a cycle where req_valid and req_ready are both high;
  // once raised, req_valid and the request fields stay constant until that cycle. Exactly one
  // resp_valid pulse follows each transferred request, in order.

  state_t            state;
  logic              discard;
  logic [2:0]        ld_width;
  logic [2:0]        ld_off;
  logic              misaligned;
  logic [NBYTES-1:0] st_wmask;
  logic [XLEN-1:0]   st_wdata;
  logic [XLEN-1:0]   ld_ext;
  logic              access_ok;
  logic              start;

  mem_align u_align (
    .width      (memdata_width_mem),
    .addr       (alu_res_mem),
    .rs2        (rs2_data_mem),
    .misaligned (misaligned),
    .wmask      (st_wmask),
    .wdata      (st_wdata),
    .ld_width   (ld_width),
    .ld_off     (ld_off),
    .rdata      (resp_rdata),
    .ld_ext     (ld_ext)
  );

  assign access_ok      = valid_mem & (is_load_mem | we_mem_mem) & ~kill_mem & ~flush;
  assign start          = access_ok & ~misaligned;
  assign misalign_exc   = (state == IDLE) & access_ok & misaligned;
  assign misalign_store = ~is_load_mem;
  assign bad_addr       = alu_res_mem;
  assign mem_stall      = ((state == IDLE) & start) | (state == REQ) | (state == RESP);
  assign fsm_state      = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_valid <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wmask <= '0;
      load_data <= '0;
      discard   <= 1'b0;
      ld_width  <= MW_D;
      ld_off    <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          discard <= 1'b0;
          if (start) begin
            state     <= REQ;
            req_valid <= 1'b1;
            req_we    <= ~is_load_mem;
            req_addr  <= {alu_res_mem[XLEN-1:3], 3'b000};
            req_wdata <= is_load_mem ? '0 : st_wdata;
            req_wmask <= is_load_mem ? '0 : st_wmask;
            ld_width  <= memdata_width_mem;
            ld_off    <= alu_res_mem[2:0];
          end
        end
        REQ: begin
          // A flush cannot withdraw a visible request; remember to drop its result instead.
          if (flush) discard <= 1'b1;
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (resp_valid) begin
            if (discard || flush) begin
              state <= IDLE;
            end else begin
              if (!req_we) load_data <= ld_ext;
              state <= DONE;
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        DONE: begin
          if (flush || !pipe_stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: driver tasks push expected bus requests and load results, a monitor checks them.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_mem, kill_mem, flush, pipe_stall, is_load_mem, we_mem_mem;
  logic [2:0]  memdata_width_mem;
  logic [63:0] alu_res_mem, rs2_data_mem;
  logic        req_valid, req_ready, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        mem_stall;
  logic [63:0] load_data;
  logic        misalign_exc, misalign_store;
  logic [63:0] bad_addr;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  logic [136:0] exp_req_q[$];   // {we, addr, wdata, wmask}
  logic [64:0]  exp_done_q[$];  // {is_load, load_data}

  mem_access_unit dut (
    .clk(clk), .rst(rst), .valid_mem(valid_mem), .kill_mem(kill_mem), .flush(flush),
    .pipe_stall(pipe_stall), .is_load_mem(is_load_mem), .we_mem_mem(we_mem_mem),
    .memdata_width_mem(memdata_width_mem), .alu_res_mem(alu_res_mem), .rs2_data_mem(rs2_data_mem),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_stall(mem_stall), .load_data(load_data), .misalign_exc(misalign_exc),
    .misalign_store(misalign_store), .bad_addr(bad_addr), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: request handshakes and first DONE cycle of each transaction
  logic [1:0] prev_state = 2'd0;
  always @(negedge clk) begin
    logic [136:0] er;
    logic [64:0]  ed;
    if (!rst && req_valid && req_ready) begin
      if (exp_req_q.size() == 0) begin
        chk("unexpected_req", 64'd1, 64'd0);
      end else begin
        er = exp_req_q.pop_front();
        chk("req_we",    {63'd0, req_we}, {63'd0, er[136]});
        chk("req_addr",  req_addr, er[135:72]);
        chk("req_wdata", req_wdata, er[71:8]);
        chk("req_wmask", {56'd0, req_wmask}, {56'd0, er[7:0]});
      end
    end
    if (!rst && fsm_state == 2'd3 && prev_state != 2'd3) begin
      done_cnt++;
      if (exp_done_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        ed = exp_done_q.pop_front();
        if (ed[64]) chk("load_data", load_data, ed[63:0]);
      end
    end
    prev_state = fsm_state;
  end

  task automatic idle_inputs();
    valid_mem = 0; kill_mem = 0; flush = 0; pipe_stall = 0; is_load_mem = 0; we_mem_mem = 0;
    memdata_width_mem = 3'b000; alu_res_mem = '0; rs2_data_mem = '0;
    req_ready = 0; resp_valid = 0; resp_rdata = '0;
  endtask

  // driver: one full load/store through a bus with the given ready/response delays
  task automatic access(input string nm, input logic ld, input logic [2:0] w, input logic [63:0] a,
                        input logic [63:0] rs2, input logic [63:0] rd, input logic [63:0] exp_ld,
                        input logic [63:0] exp_wd, input logic [7:0] exp_wm,
                        input int rdy_dly, input int rsp_dly, input logic fl);
    int done_before;
    logic [63:0] exp_addr;
    exp_addr = {a[63:3], 3'b000};
    exp_req_q.push_back({!ld, exp_addr, exp_wd, exp_wm});
    if (!fl) exp_done_q.push_back({ld, exp_ld});
    done_before = done_cnt;
    valid_mem = 1; is_load_mem = ld; we_mem_mem = !ld; memdata_width_mem = w;
    alu_res_mem = a; rs2_data_mem = rs2;
    @(negedge clk);
    chk({nm, "_stall_start"}, {63'd0, mem_stall}, 64'd1);
    @(posedge clk); #1;
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      chk({nm, "_wait_valid"}, {63'd0, req_valid}, 64'd1);
      chk({nm, "_wait_addr"}, req_addr, exp_addr);
      chk({nm, "_wait_stall"}, {63'd0, mem_stall}, 64'd1);
      @(posedge clk); #1;
    end
    req_ready = 1;
    @(posedge clk); #1;
    req_ready = 0;
    for (int i = 0; i < rsp_dly; i++) begin
      if (fl && i == 0) flush = 1;
      @(negedge clk);
      chk({nm, "_resp_stall"}, {63'd0, mem_stall}, 64'd1);
      chk({nm, "_resp_novalid"}, {63'd0, req_valid}, 64'd0);
      @(posedge clk); #1;
      flush = 0;
    end
    resp_valid = 1; resp_rdata = rd;
    @(posedge clk); #1;
    resp_valid = 0; valid_mem = 0;
    @(negedge clk);
    if (fl) begin
      chk({nm, "_flush_idle"}, {62'd0, fsm_state}, 64'd0);
    end else begin
      chk({nm, "_done_state"}, {62'd0, fsm_state}, 64'd3);
      chk({nm, "_done_nostall"}, {63'd0, mem_stall}, 64'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_back_idle"}, {62'd0, fsm_state}, 64'd0);
    chk({nm, "_done_count"}, 64'(done_cnt - done_before), fl ? 64'd0 : 64'd1);
    @(posedge clk); #1;
  endtask

  // driver: misaligned or suppressed access that must not start the engine
  task automatic no_start(input string nm, input logic ld, input logic [2:0] w, input logic [63:0] a,
                          input logic kill, input logic fl, input logic exp_exc);
    valid_mem = 1; is_load_mem = ld; we_mem_mem = !ld; memdata_width_mem = w;
    alu_res_mem = a; kill_mem = kill; flush = fl;
    @(negedge clk);
    chk({nm, "_exc"}, {63'd0, misalign_exc}, {63'd0, exp_exc});
    if (exp_exc) begin
      chk({nm, "_exc_store"}, {63'd0, misalign_store}, {63'd0, !ld});
      chk({nm, "_bad_addr"}, bad_addr, a);
    end
    chk({nm, "_nostall"}, {63'd0, mem_stall}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_stay_idle"}, {62'd0, fsm_state}, 64'd0);
    chk({nm, "_noreq"}, {63'd0, req_valid}, 64'd0);
    valid_mem = 0; kill_mem = 0; flush = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {62'd0, fsm_state}, 64'd0);
    chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
    chk("rst_req_addr", req_addr, 64'd0);
    chk("rst_req_wmask", {56'd0, req_wmask}, 64'd0);
    chk("rst_load_data", load_data, 64'd0);
    chk("rst_mem_stall", {63'd0, mem_stall}, 64'd0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    access("lb_pos", 1, 3'b000, 64'h1003, 0, 64'h8877_6655_4433_2211, 64'h0000_0000_0000_0044, 0, 8'h00, 0, 0, 0);
    access("lb_neg", 1, 3'b000, 64'h1007, 0, 64'h8877_6655_4433_2211, 64'hFFFF_FFFF_FFFF_FF88, 0, 8'h00, 0, 0, 0);
    access("sw", 0, 3'b010, 64'h2004, 64'h0000_0000_DEAD_BEEF, 0, 0, 64'hDEAD_BEEF_0000_0000, 8'hF0, 0, 0, 0);
    access("sb", 0, 3'b000, 64'h6005, 64'h1122_3344_5566_77AB, 0, 0, 64'h6677_AB00_0000_0000, 8'h20, 0, 0, 0);
    access("sh", 0, 3'b001, 64'h6002, 64'h0000_0000_0000_1234, 0, 0, 64'h0000_0000_1234_0000, 8'h0C, 1, 0, 0);
    access("sd", 0, 3'b011, 64'h7000, 64'hCAFE_F00D_1234_5678, 0, 0, 64'hCAFE_F00D_1234_5678, 8'hFF, 0, 1, 0);
    access("lw", 1, 3'b010, 64'h8004, 0, 64'h9000_0000_1111_1111, 64'hFFFF_FFFF_9000_0000, 0, 8'h00, 0, 0, 0);
    access("lwu", 1, 3'b110, 64'h8004, 0, 64'h9000_0000_1111_1111, 64'h0000_0000_9000_0000, 0, 8'h00, 0, 0, 0);
    access("lh", 1, 3'b001, 64'h8006, 0, 64'h9000_0000_1111_1111, 64'hFFFF_FFFF_FFFF_9000, 0, 8'h00, 0, 0, 0);
    access("w111", 1, 3'b111, 64'h4010, 0, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210, 0, 8'h00, 0, 0, 0);
    access("ld_slow", 1, 3'b011, 64'h4008, 0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 0, 8'h00, 3, 2, 0);
    access("lhu_flush", 1, 3'b101, 64'h5006, 0, 64'hFFEE_DDCC_BBAA_9988, 0, 0, 8'h00, 0, 2, 1);
    @(negedge clk);
    chk("flush_keeps_load_data", load_data, 64'h0123_4567_89AB_CDEF);
    @(posedge clk); #1;

    no_start("lw_misalign", 1, 3'b010, 64'h3002, 0, 0, 1);
    no_start("sd_misalign", 0, 3'b011, 64'h3004, 0, 0, 1);
    no_start("w111_misalign", 1, 3'b111, 64'h4011, 0, 0, 1);
    no_start("killed", 1, 3'b010, 64'h3002, 1, 0, 0);
    no_start("flushed", 1, 3'b011, 64'h3000, 0, 1, 0);

    // reset while a request is waiting for ready
    valid_mem = 1; is_load_mem = 1; we_mem_mem = 0; memdata_width_mem = 3'b001; alu_res_mem = 64'h9002;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_req_valid", {63'd0, req_valid}, 64'd1);
    rst = 1; valid_mem = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_state", {62'd0, fsm_state}, 64'd0);
    chk("rstmid_req_valid0", {63'd0, req_valid}, 64'd0);
    chk("rstmid_mem_stall", {63'd0, mem_stall}, 64'd0);
    chk("rstmid_load_data", load_data, 64'd0);
    @(posedge clk); #1;
    rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("req_queue_empty", 64'(exp_req_q.size()), 64'd0);
    chk("done_queue_empty", 64'(exp_done_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
